// File: rtl/breakout_pkg.sv
// Shared Breakout constants: screen and wall geometry, wall-hit codes,
// datapath widths and the ball_motion state encoding. Also used by the
// wall-collision checker.
package breakout_pkg;

  localparam int unsigned SCREEN_W     = 320;
  localparam int unsigned SCREEN_H     = 240;

  localparam int unsigned LEFT_WALL_X  = 8;
  localparam int unsigned RIGHT_WALL_X = 312;
  localparam int unsigned TOP_WALL_Y   = 8;
  localparam int unsigned BOTTOM_Y     = 232;

  localparam int unsigned X_W          = 9;
  localparam int unsigned Y_W          = 8;
  // One spare bit over the widest axis so stepping never wraps.
  localparam int unsigned AXIS_W       = 10;
  localparam int unsigned STEP_W       = 4;

  localparam logic [1:0] HIT_NONE  = 2'd0;
  localparam logic [1:0] HIT_LEFT  = 2'd1;
  localparam logic [1:0] HIT_TOP   = 2'd2;
  localparam logic [1:0] HIT_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    LOST = 2'd2
  } ball_state_e;

endpackage

// File: rtl/ball_axis_step.sv
// Combinational one-axis step: moves pos by step in the given direction
// and clamps to [min_pos, max_pos].
//   pos, dir (1 = increasing), step, min_pos, max_pos -> next_pos
//   reached_max : high when an increasing step lands on or beyond max_pos
module ball_axis_step
  import breakout_pkg::*;
(
  input  logic [AXIS_W-1:0] pos,
  input  logic              dir,
  input  logic [STEP_W-1:0] step,
  input  logic [AXIS_W-1:0] min_pos,
  input  logic [AXIS_W-1:0] max_pos,
  output logic [AXIS_W-1:0] next_pos,
  output logic              reached_max
);

  localparam int unsigned SUM_W = AXIS_W + 1;

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] floor_lim;

  // Compare before subtracting so a decreasing step never underflows.
  always_comb begin
    sum         = SUM_W'(pos) + SUM_W'(step);
    floor_lim   = SUM_W'(min_pos) + SUM_W'(step);
    next_pos    = pos;
    reached_max = 1'b0;
    if (dir) begin
      if (sum >= SUM_W'(max_pos)) begin
        next_pos    = max_pos;
        reached_max = 1'b1;
      end else begin
        next_pos = AXIS_W'(sum);
      end
    end else begin
      if (SUM_W'(pos) >= floor_lim) next_pos = pos - AXIS_W'(step);
      else                          next_pos = min_pos;
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Breakout ball position/direction owner. Parks the ball on the paddle in
// IDLE, launches on serve, steps once per frame_tick in MOVE with wall and
// paddle reflection, and signals loss at the bottom of the playfield.
//   clk, reset (async, active-low)
//   frame_tick : one-cycle per-frame enable
//   wall_hit   : lagged wall code from the collision checker
//   paddle_hit : ball overlapping paddle this frame
//   paddle_x   : paddle left edge
//   serve      : one-cycle launch request
//   ball_x, ball_y, dir_x, dir_y, moving, ball_lost : registered outputs
// Build option: BALL_SPEEDUP_EN raises the step by one every 4th paddle
// reflection, saturating at 2*STEP.
module ball_motion
  import breakout_pkg::*;
#(
  parameter int unsigned STEP     = 2,
  parameter int unsigned SERVE_Y  = 220,
  parameter int unsigned PADDLE_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_tick,
  input  logic [1:0]     wall_hit,
  input  logic           paddle_hit,
  input  logic [X_W-1:0] paddle_x,
  input  logic           serve,
  output logic [X_W-1:0] ball_x,
  output logic [Y_W-1:0] ball_y,
  output logic           dir_x,
  output logic           dir_y,
  output logic           moving,
  output logic           ball_lost
);

  ball_state_e       state_q, state_d;
  logic [X_W-1:0]    x_d;
  logic [Y_W-1:0]    y_d;
  logic              dir_x_d, dir_y_d, moving_d, lost_d;
  logic              dir_x_res, dir_y_res;
  logic [STEP_W-1:0] cur_step;
  logic [AXIS_W-1:0] x_next, y_next, track_sum;
  logic [X_W-1:0]    track_x;
  logic              y_at_bottom, x_max_unused;

  // Active step size.
`ifdef BALL_SPEEDUP_EN
  logic [2:0]        refl_q;
  logic [STEP_W-1:0] step_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refl_q <= 3'd0;
      step_q <= STEP_W'(STEP);
    end else if (state_q == LOST) begin
      refl_q <= 3'd0;
      step_q <= STEP_W'(STEP);
    end else if (state_q == MOVE && frame_tick && paddle_hit && dir_y) begin
      refl_q <= refl_q + 3'd1;
      if (refl_q[1:0] == 2'd3 && step_q < STEP_W'(2 * STEP))
        step_q <= step_q + STEP_W'(1);
    end
  end

  assign cur_step = step_q;
`else
  assign cur_step = STEP_W'(STEP);
`endif

  // Directions are set absolutely; paddle beats a top-wall hit.
  always_comb begin
    dir_x_res = dir_x;
    dir_y_res = dir_y;
    if (wall_hit == HIT_LEFT)  dir_x_res = 1'b1;
    if (wall_hit == HIT_RIGHT) dir_x_res = 1'b0;
    if (wall_hit == HIT_TOP)   dir_y_res = 1'b1;
    if (paddle_hit)            dir_y_res = 1'b0;
  end

  ball_axis_step u_step_x (
    .pos         (AXIS_W'(ball_x)),
    .dir         (dir_x_res),
    .step        (cur_step),
    .min_pos     (AXIS_W'(LEFT_WALL_X)),
    .max_pos     (AXIS_W'(RIGHT_WALL_X)),
    .next_pos    (x_next),
    .reached_max (x_max_unused)
  );

  ball_axis_step u_step_y (
    .pos         (AXIS_W'(ball_y)),
    .dir         (dir_y_res),
    .step        (cur_step),
    .min_pos     (AXIS_W'(TOP_WALL_Y)),
    .max_pos     (AXIS_W'(BOTTOM_Y)),
    .next_pos    (y_next),
    .reached_max (y_at_bottom)
  );

  // Parked x: paddle centre, saturated at the right wall.
  always_comb begin
    track_sum = AXIS_W'(paddle_x) + AXIS_W'(PADDLE_W / 2);
    if (track_sum > AXIS_W'(RIGHT_WALL_X)) track_x = X_W'(RIGHT_WALL_X);
    else                                   track_x = X_W'(track_sum);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    x_d      = ball_x;
    y_d      = ball_y;
    dir_x_d  = dir_x;
    dir_y_d  = dir_y;
    lost_d   = 1'b0;
    moving_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (serve) begin
          state_d = MOVE;
          dir_x_d = 1'b1;
          dir_y_d = 1'b0;
        end else if (frame_tick) begin
          x_d = track_x;
          y_d = Y_W'(SERVE_Y);
        end
      end
      MOVE: begin
        if (frame_tick) begin
          dir_x_d = dir_x_res;
          dir_y_d = dir_y_res;
          x_d     = X_W'(x_next);
          if (y_at_bottom) begin
            y_d     = Y_W'(BOTTOM_Y);
            lost_d  = 1'b1;
            state_d = LOST;
            dir_x_d = 1'b1;
            dir_y_d = 1'b0;
          end else begin
            y_d = Y_W'(y_next);
          end
        end
      end
      LOST: begin
        state_d = IDLE;
        dir_x_d = 1'b1;
        dir_y_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    moving_d = (state_d == MOVE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ball_x    <= X_W'(SCREEN_W / 2);
      ball_y    <= Y_W'(SERVE_Y);
      dir_x     <= 1'b1;
      dir_y     <= 1'b0;
      moving    <= 1'b0;
      ball_lost <= 1'b0;
    end else begin
      state_q   <= state_d;
      ball_x    <= x_d;
      ball_y    <= y_d;
      dir_x     <= dir_x_d;
      dir_y     <= dir_y_d;
      moving    <= moving_d;
      ball_lost <= lost_d;
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
module tb_ball_motion;

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic [1:0] wall_hit;
  logic       paddle_hit;
  logic [8:0] paddle_x;
  logic       serve;
  logic [8:0] ball_x;
  logic [7:0] ball_y;
  logic       dir_x, dir_y, moving, ball_lost;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic       tick;
    logic [1:0] wh;
    logic       ph;
    logic [8:0] px;
    logic       srv;
    logic [8:0] ex;
    logic [7:0] ey;
    logic       edx;
    logic       edy;
    logic       emv;
    logic       elost;
  } vec_t;

  vec_t vecs[$];

  ball_motion dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .wall_hit   (wall_hit),
    .paddle_hit (paddle_hit),
    .paddle_x   (paddle_x),
    .serve      (serve),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .dir_x      (dir_x),
    .dir_y      (dir_y),
    .moving     (moving),
    .ball_lost  (ball_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic t, input logic [1:0] wh,
                              input logic ph, input logic [8:0] px, input logic s,
                              input logic [8:0] ex, input logic [7:0] ey,
                              input logic edx, input logic edy, input logic emv,
                              input logic el);
    vec_t v;
    v.rst = r; v.tick = t; v.wh = wh; v.ph = ph; v.px = px; v.srv = s;
    v.ex = ex; v.ey = ey; v.edx = edx; v.edy = edy; v.emv = emv; v.elost = el;
    vecs.push_back(v);
  endfunction

  // One clock cycle of stimulus; returns 1 time unit after the rising edge.
  task automatic cyc(input logic r, input logic t, input logic [1:0] wh,
                     input logic ph, input logic [8:0] px, input logic s);
    @(negedge clk);
    reset      = ~r;
    frame_tick = t;
    wall_hit   = wh;
    paddle_hit = ph;
    paddle_x   = px;
    serve      = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [8:0] ex, input logic [7:0] ey,
                       input logic edx, input logic edy, input logic emv, input logic el);
    total++;
    if (ball_x !== ex || ball_y !== ey || dir_x !== edx || dir_y !== edy ||
        moving !== emv || ball_lost !== el) begin
      bad++;
      $display("FAIL %s: got x=%0d y=%0d dx=%0d dy=%0d mv=%0d lost=%0d, want x=%0d y=%0d dx=%0d dy=%0d mv=%0d lost=%0d",
               name, ball_x, ball_y, dir_x, dir_y, moving, ball_lost,
               ex, ey, edx, edy, emv, el);
    end
  endtask

  initial begin
    reset = 1'b0; frame_tick = 1'b0; wall_hit = 2'd0; paddle_hit = 1'b0;
    paddle_x = 9'd0; serve = 1'b0;

    //  rst tk wh ph  px srv    x   y  dx dy mv lost
    add(1, 0, 0, 0,   0, 0,  160, 220, 1, 0, 0, 0);
    add(0, 1, 0, 0, 150, 0,  166, 220, 1, 0, 0, 0);
    add(0, 0, 0, 0, 150, 1,  166, 220, 1, 0, 1, 0);
    add(0, 1, 0, 0, 150, 0,  168, 218, 1, 0, 1, 0);
    add(0, 0, 3, 0, 150, 1,  168, 218, 1, 0, 1, 0);
    // left wall reflection, repeated stale code
    add(1, 0, 0, 0,   0, 0,  160, 220, 1, 0, 0, 0);
    add(0, 1, 0, 0,   0, 0,   16, 220, 1, 0, 0, 0);
    add(0, 0, 0, 0,   0, 1,   16, 220, 1, 0, 1, 0);
    add(0, 1, 3, 0,   0, 0,   14, 218, 0, 0, 1, 0);
    add(0, 1, 3, 0,   0, 0,   12, 216, 0, 0, 1, 0);
    add(0, 1, 3, 0,   0, 0,   10, 214, 0, 0, 1, 0);
    add(0, 1, 1, 0,   0, 0,   12, 212, 1, 0, 1, 0);
    add(0, 1, 1, 0,   0, 0,   14, 210, 1, 0, 1, 0);
    // right clamp, right reflection, descent to loss
    add(1, 0, 0, 0,   0, 0,  160, 220, 1, 0, 0, 0);
    add(0, 1, 0, 0, 295, 0,  311, 220, 1, 0, 0, 0);
    add(0, 0, 0, 0, 295, 1,  311, 220, 1, 0, 1, 0);
    add(0, 1, 0, 0, 295, 0,  312, 218, 1, 0, 1, 0);
    add(0, 1, 3, 0, 295, 0,  310, 216, 0, 0, 1, 0);
    add(0, 1, 2, 0, 295, 0,  308, 218, 0, 1, 1, 0);
    add(0, 1, 0, 0, 295, 0,  306, 220, 0, 1, 1, 0);
    add(0, 1, 0, 0, 295, 0,  304, 222, 0, 1, 1, 0);
    add(0, 1, 0, 0, 295, 0,  302, 224, 0, 1, 1, 0);
    add(0, 1, 0, 0, 295, 0,  300, 226, 0, 1, 1, 0);
    add(0, 1, 0, 0, 295, 0,  298, 228, 0, 1, 1, 0);
    add(0, 1, 0, 0, 295, 0,  296, 230, 0, 1, 1, 0);
    add(0, 1, 0, 0, 295, 0,  294, 232, 1, 0, 0, 1);
    add(0, 0, 0, 0, 295, 0,  294, 232, 1, 0, 0, 0);
    add(0, 1, 0, 0, 100, 0,  116, 220, 1, 0, 0, 0);
    add(0, 0, 0, 0, 100, 1,  116, 220, 1, 0, 1, 0);
    add(0, 1, 0, 0, 100, 0,  118, 218, 1, 0, 1, 0);
    // parked saturation, serve beats tick, paddle while rising
    add(1, 0, 0, 0,   0, 0,  160, 220, 1, 0, 0, 0);
    add(0, 1, 0, 0, 511, 0,  312, 220, 1, 0, 0, 0);
    add(0, 1, 0, 0,   0, 1,  312, 220, 1, 0, 1, 0);
    add(0, 1, 0, 0,   0, 0,  312, 218, 1, 0, 1, 0);
    add(0, 1, 3, 1,   0, 0,  310, 216, 0, 0, 1, 0);
    add(0, 1, 2, 0,   0, 0,  308, 218, 0, 1, 1, 0);
    add(0, 1, 0, 1,   0, 0,  306, 216, 0, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].tick, vecs[i].wh, vecs[i].ph, vecs[i].px, vecs[i].srv);
      check($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].edx,
            vecs[i].edy, vecs[i].emv, vecs[i].elost);
    end

    // Asynchronous reset in the middle of a clock period while moving.
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset", 9'd160, 8'd220, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_hold", 9'd160, 8'd220, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(0, 0, 0, 0, 0, 0);
    check("reset_release", 9'd160, 8'd220, 1'b1, 1'b0, 1'b0, 1'b0);

    // Climb to the top wall with x oscillating between walls codes.
    cyc(0, 1, 0, 0, 0, 0);
    check("top_park", 9'd16, 8'd220, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 105; k++)
      cyc(0, 1, (k % 2 == 0) ? 2'd1 : 2'd3, 0, 0, 0);
    check("top_approach", 9'd18, 8'd10, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(0, 1, 2, 1, 0, 0);
    check("top_paddle_prio", 9'd20, 8'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(0, 1, 0, 0, 0, 0);
    check("top_clamp_hold", 9'd22, 8'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(0, 1, 2, 0, 0, 0);
    check("top_reflect", 9'd24, 8'd10, 1'b1, 1'b1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
